// File: rtl/stream_mux.sv
// ============================================================================
// Module   : stream_mux
// Brief    : Registered N-channel valid/ready stream mux, manual or round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] d,
    input  logic [N-1:0]       d_valid,
    output logic [N-1:0]       d_ready,
    input  logic [SELW-1:0]    s,
    input  logic               mode,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [SELW-1:0]    y_sel
);

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SELW-1:0]  y_sel_q, y_sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic             grant;
    logic [SELW-1:0]  g;
    logic [WIDTH-1:0] g_data;
    int               idx;

    assign load_en = !y_valid_q || y_ready;

    always_comb begin
        grant = 1'b0;
        g     = '0;
        idx   = 0;
        if (!mode) begin
            // Iterating channels keeps an out-of-range s from ever granting.
            for (int i = 0; i < N; i++) begin
                if (s == SELW'(i) && d_valid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
        end else begin
            // Scan farthest offset first so the nearest valid channel from ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (d_valid[idx]) begin
                    grant = 1'b1;
                    g     = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        g_data  = '0;
        d_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                g_data = d[i*WIDTH +: WIDTH];
            end
            d_ready[i] = rst_n && load_en && grant && (g == SELW'(i));
        end
    end

    always_comb begin
        y_d       = y_q;
        y_sel_d   = y_sel_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        if (load_en && grant) begin
            y_d       = g_data;
            y_sel_d   = g;
            y_valid_d = 1'b1;
            if (mode) begin
                ptr_d = (g == SELW'(N - 1)) ? '0 : g + 1'b1;
            end
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_sel_q   <= '0;
            ptr_q     <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_sel_q   <= y_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_sel   = y_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux.sv
// ============================================================================
// Module   : tb_stream_mux
// Brief    : Directed self-checking bench for stream_mux (N=4 and N=3 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux;

    logic        clk;
    logic        rst_n;

    logic [31:0] d;
    logic [3:0]  d_valid;
    logic [3:0]  d_ready;
    logic [1:0]  s;
    logic        mode;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  y_sel;

    logic [23:0] b_d;
    logic [2:0]  b_d_valid;
    logic [2:0]  b_d_ready;
    logic [1:0]  b_s;
    logic        b_mode;
    logic [7:0]  b_y;
    logic        b_y_valid;
    logic        b_y_ready;
    logic [1:0]  b_y_sel;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] sb_q[$];

    stream_mux #(.WIDTH(8), .N(4), .SELW(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_ready(d_ready),
        .s(s), .mode(mode), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_sel(y_sel)
    );

    stream_mux #(.WIDTH(8), .N(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .d(b_d), .d_valid(b_d_valid), .d_ready(b_d_ready),
        .s(b_s), .mode(b_mode), .y(b_y), .y_valid(b_y_valid), .y_ready(b_y_ready),
        .y_sel(b_y_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i on the N=4 build carries 8'h11*(i+1).
    task automatic chk_y(input string tag, input int sel);
        logic [7:0] exp_y;
        exp_y = 8'(8'h11 * (sel + 1));
        chk({tag, "_sel"}, 32'(y_sel), 32'(sel));
        chk({tag, "_y"}, 32'(y), 32'(exp_y));
        chk({tag, "_vld"}, 32'(y_valid), 32'd1);
    endtask

    // Word-level scoreboard: drain is popped before the same-edge load is pushed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (y_valid && y_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 32'(y), 32'hffff_ffff);
                end else begin
                    chk("sb_word", 32'(y), 32'(sb_q.pop_front()));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (d_ready[i] && d_valid[i]) begin
                    sb_q.push_back(d[i*8 +: 8]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rr_all[5];
        int rr_alt[5];
        rr_all = '{0, 1, 2, 3, 0};
        rr_alt = '{1, 3, 1, 3, 1};

        rst_n     = 1'b0;
        d         = {8'h44, 8'h33, 8'h22, 8'h11};
        d_valid   = 4'b1111;
        s         = 2'd0;
        mode      = 1'b1;
        y_ready   = 1'b0;
        b_d       = {8'h33, 8'h22, 8'h11};
        b_d_valid = 3'b000;
        b_s       = 2'd0;
        b_mode    = 1'b0;
        b_y_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_vld", 32'(y_valid), 32'h0);
        chk("rst_sel", 32'(y_sel), 32'h0);
        chk("rst_rdy", 32'(d_ready), 32'h0);

        rst_n   = 1'b1;
        y_ready = 1'b1;
        #1;
        chk("rr_first_rdy", 32'(d_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_y("rr_all", rr_all[i]);
        end

        d_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_y("rr_alt", rr_alt[i]);
        end

        mode    = 1'b0;
        s       = 2'd2;
        d_valid = 4'b1111;
        #1;
        chk("man_rdy", 32'(d_ready), 32'b0100);
        tick();
        chk_y("man_s2", 2);

        d_valid = 4'b1011;
        #1;
        chk("man_novld_rdy", 32'(d_ready), 32'h0);
        tick();
        chk("man_drain_vld", 32'(y_valid), 32'h0);
        chk("man_drain_y", 32'(y), 32'h33);
        chk("man_drain_sel", 32'(y_sel), 32'd2);

        s       = 2'd1;
        d_valid = 4'b1111;
        #1;
        chk("bp_load_rdy", 32'(d_ready), 32'b0010);
        tick();
        chk_y("bp_load", 1);

        y_ready = 1'b0;
        s       = 2'd3;
        #1;
        chk("bp_rdy", 32'(d_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_y("bp_hold", 1);
            chk("bp_hold_rdy", 32'(d_ready), 32'h0);
        end

        y_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(d_ready), 32'b1000);
        tick();
        chk_y("bp_swap", 3);

        // ptr is 2 here; reset must bring round-robin back to channel 0.
        y_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(y_valid), 32'h0);
        chk("arst_y", 32'(y), 32'h0);
        chk("arst_sel", 32'(y_sel), 32'h0);
        chk("arst_rdy", 32'(d_ready), 32'h0);
        sb_q.delete();
        tick();
        rst_n   = 1'b1;
        mode    = 1'b1;
        d_valid = 4'b1111;
        y_ready = 1'b1;
        #1;
        chk("arst_rr_rdy", 32'(d_ready), 32'b0001);
        tick();
        chk_y("arst_rr", 0);
        d_valid = 4'b0000;
        y_ready = 1'b0;

        b_mode    = 1'b0;
        b_s       = 2'd3;
        b_d_valid = 3'b111;
        b_y_ready = 1'b1;
        #1;
        chk("n3_s3_rdy", 32'(b_d_ready), 32'h0);
        tick();
        chk("n3_s3_vld", 32'(b_y_valid), 32'h0);

        b_mode = 1'b1;
        #1;
        chk("n3_rr_rdy", 32'(b_d_ready), 32'b001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n3_rr_sel", 32'(b_y_sel), 32'(i % 3));
            chk("n3_rr_y", 32'(b_y), 32'(8'h11 * ((i % 3) + 1)));
            chk("n3_rr_vld", 32'(b_y_valid), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
